// File: rtl/mic1_word_assembler_pkg.sv
// Shared MIC-1 host-link types: lane/byte/word widths and lane enumeration.
package mic1_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_e;

    function automatic lane_e next_lane(input lane_e cur);
        return lane_e'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/mic1_word_assembler_if.sv
// Byte-in / word-out handshake bundle; sync/frame_err exist only with MIC1_ASM_SYNC_EN.
interface mic1_word_assembler_if;
    import mic1_pkg::*;

    logic  byte_valid;
    byte_t byte_data;
    logic  byte_ready;
    logic  word_valid;
    word_t word_data;
    logic  word_ready;
`ifdef MIC1_ASM_SYNC_EN
    logic  sync;
    logic  frame_err;
`endif

    modport master (
        output byte_valid, byte_data, word_ready,
`ifdef MIC1_ASM_SYNC_EN
        output sync,
        input  frame_err,
`endif
        input  byte_ready, word_valid, word_data
    );

    modport slave (
        input  byte_valid, byte_data, word_ready,
`ifdef MIC1_ASM_SYNC_EN
        input  sync,
        output frame_err,
`endif
        output byte_ready, word_valid, word_data
    );

endinterface

// File: rtl/mic1_word_assembler_word_hold.sv
// Single-entry valid/ready holding register for completed words.
module mic1_word_hold
    import mic1_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  word_t din,
    input  logic  ready,
    output logic  valid,
    output word_t dout
);

    // Caller never loads while full and not draining, so load wins outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mic1_word_assembler.sv
// Little-endian byte-to-word deserializer; optional lane-0 resync via MIC1_ASM_SYNC_EN.
module mic1_word_assembler
    import mic1_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mic1_word_assembler_if.slave  bus
);

    lane_e                             r_lane;
    logic [BYTE_W*(LANES-1)-1:0]       r_part;
    logic                              w_hold_valid;
    word_t                             w_hold_data;
    logic                              w_byte_ready;
    logic                              w_accept;
    logic                              w_sync;
    logic                              w_load;

    assign w_byte_ready = !(r_lane == LANE3 && w_hold_valid && !bus.word_ready);
    assign w_accept     = bus.byte_valid && w_byte_ready;

`ifdef MIC1_ASM_SYNC_EN
    logic r_frame_err;

    assign w_sync = w_accept && bus.sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_sync && (r_lane != LANE0);
        end
    end

    assign bus.frame_err = r_frame_err;
`else
    assign w_sync = 1'b0;
`endif

    // A sync byte is lane 0 by definition, so it never completes a word.
    assign w_load = w_accept && !w_sync && (r_lane == LANE3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= LANE0;
            r_part <= '0;
        end else if (w_accept) begin
            if (w_sync) begin
                r_part[0 +: BYTE_W] <= bus.byte_data;
                r_lane              <= LANE1;
            end else begin
                case (r_lane)
                    LANE0:   r_part[0        +: BYTE_W] <= bus.byte_data;
                    LANE1:   r_part[BYTE_W   +: BYTE_W] <= bus.byte_data;
                    LANE2:   r_part[2*BYTE_W +: BYTE_W] <= bus.byte_data;
                    default: ;
                endcase
                r_lane <= next_lane(r_lane);
            end
        end
    end

    mic1_word_hold u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .din   ({bus.byte_data, r_part}),
        .ready (bus.word_ready),
        .valid (w_hold_valid),
        .dout  (w_hold_data)
    );

    assign bus.byte_ready = w_byte_ready;
    assign bus.word_valid = w_hold_valid;
    assign bus.word_data  = w_hold_data;

endmodule

// File: tb/tb_mic1_word_assembler.sv
// Self-checking bench for mic1_word_assembler; sync scenarios run when MIC1_ASM_SYNC_EN is defined.
module tb_mic1_word_assembler;
    import mic1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   words_seen = 0;

    mic1_word_assembler_if bus();

    mic1_word_assembler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: bytes of the word in progress, plus the output slot.
    byte_t m_bytes[$];
    bit    m_hv   = 1'b0;
    word_t m_hd   = '0;
    bit    m_ferr = 1'b0;

    function automatic bit model_ready();
        return !(m_bytes.size() == 3 && m_hv && !bus.word_ready);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bytes.delete();
            m_hv   = 1'b0;
            m_hd   = '0;
            m_ferr = 1'b0;
        end else begin
            bit    acc;
            bit    s;
            bit    nw;
            word_t w;
            acc = bus.byte_valid && model_ready();
            s   = 1'b0;
`ifdef MIC1_ASM_SYNC_EN
            s = bus.sync;
`endif
            nw     = 1'b0;
            w      = '0;
            m_ferr = 1'b0;
            if (m_hv && bus.word_ready) words_seen++;
            if (acc) begin
                if (s) begin
                    m_ferr = (m_bytes.size() != 0);
                    m_bytes.delete();
                end
                m_bytes.push_back(bus.byte_data);
                if (m_bytes.size() == LANES) begin
                    for (int i = 0; i < LANES; i++) w = w | (word_t'(m_bytes[i]) << (8 * i));
                    nw = 1'b1;
                    m_bytes.delete();
                end
            end
            if (nw) begin
                m_hv = 1'b1;
                m_hd = w;
            end else if (m_hv && bus.word_ready) begin
                m_hv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("byte_ready", 32'(bus.byte_ready), 32'(model_ready()));
        check("word_valid", 32'(bus.word_valid), 32'(m_hv));
        if (m_hv) check("word_data", bus.word_data, m_hd);
`ifdef MIC1_ASM_SYNC_EN
        check("frame_err", 32'(bus.frame_err), 32'(m_ferr));
`endif
    end

    // Offer one byte and return once accepted; stalls counts cycles spent waiting.
    task automatic send_byte(input byte_t b, input bit s, output int stalls);
        bit r;
        stalls = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
`ifdef MIC1_ASM_SYNC_EN
        bus.sync = s;
`else
        if (s) $display("note: sync requested without sync support");
`endif
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            r = bus.byte_ready;
            @(posedge clk);
            #1;
            if (r) begin
`ifdef MIC1_ASM_SYNC_EN
                bus.sync = 1'b0;
`endif
                return;
            end
            stalls++;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout byte=%h not accepted within 50 cycles", b);
        bus.byte_valid = 1'b0;
    endtask

    task automatic idle();
        bus.byte_valid = 1'b0;
`ifdef MIC1_ASM_SYNC_EN
        bus.sync = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int st;
        int tot;
        int w0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.word_ready = 1'b0;
`ifdef MIC1_ASM_SYNC_EN
        bus.sync = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_word_valid", 32'(bus.word_valid), 32'd0);
        check("rst_word_data", bus.word_data, 32'h0);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
        rst = 1'b0;

        // Basic assembly
        bus.word_ready = 1'b1;
        send_byte(8'h11, 1'b0, st);
        send_byte(8'h22, 1'b0, st);
        send_byte(8'h33, 1'b0, st);
        send_byte(8'h44, 1'b0, st);
        idle();
        check("basic_valid", 32'(bus.word_valid), 32'd1);
        check("basic_data", bus.word_data, 32'h44332211);
        @(posedge clk);
        #1;
        check("basic_valid_drop", 32'(bus.word_valid), 32'd0);

        // Stall at lane 3 with the output register full
        do_reset();
        bus.word_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send_byte(byte_t'(i), 1'b0, st);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h08;
        repeat (2) begin
            @(negedge clk);
            check("stall_byte_ready", 32'(bus.byte_ready), 32'd0);
            check("stall_held_data", bus.word_data, 32'h04030201);
        end
        @(posedge clk);
        #1;
        bus.word_ready = 1'b1;
        @(negedge clk);
        check("drain_byte_ready", 32'(bus.byte_ready), 32'd1);
        @(posedge clk);
        #1;
        idle();
        bus.word_ready = 1'b0;
        check("stall_next_valid", 32'(bus.word_valid), 32'd1);
        check("stall_next_data", bus.word_data, 32'h08070605);

        // Streaming 16 bytes, no back-pressure expected
        do_reset();
        bus.word_ready = 1'b1;
        w0  = words_seen;
        tot = 0;
        for (int i = 0; i < 16; i++) begin
            send_byte(byte_t'($urandom), 1'b0, st);
            tot += st;
        end
        idle();
        @(posedge clk);
        #1;
        check("stream_stalls", 32'(tot), 32'd0);
        check("stream_words", 32'(words_seen - w0), 32'd4);

        // Async reset mid-word with a word held
        do_reset();
        bus.word_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(byte_t'(8'hA0 + i), 1'b0, st);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_word_valid", 32'(bus.word_valid), 32'd0);
        check("arst_word_data", bus.word_data, 32'h0);
        check("arst_byte_ready", 32'(bus.byte_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.word_ready = 1'b1;
        send_byte(8'h10, 1'b0, st);
        send_byte(8'h20, 1'b0, st);
        send_byte(8'h30, 1'b0, st);
        send_byte(8'h40, 1'b0, st);
        idle();
        check("arst_next_data", bus.word_data, 32'h40302010);

`ifdef MIC1_ASM_SYNC_EN
        // Resync on a misaligned byte
        do_reset();
        bus.word_ready = 1'b1;
        send_byte(8'hAA, 1'b0, st);
        send_byte(8'hBB, 1'b0, st);
        send_byte(8'hCC, 1'b1, st);
        check("resync_ferr", 32'(bus.frame_err), 32'd1);
        send_byte(8'hDD, 1'b0, st);
        check("resync_ferr_drop", 32'(bus.frame_err), 32'd0);
        send_byte(8'hEE, 1'b0, st);
        send_byte(8'hFF, 1'b0, st);
        idle();
        check("resync_data", bus.word_data, 32'hFFEEDDCC);
        // Sync when already aligned
        send_byte(8'h5A, 1'b1, st);
        idle();
        check("aligned_sync_ferr", 32'(bus.frame_err), 32'd0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.byte_valid = ($urandom_range(0, 9) < 7);
            bus.byte_data  = byte_t'($urandom);
            bus.word_ready = ($urandom_range(0, 1) == 1);
`ifdef MIC1_ASM_SYNC_EN
            bus.sync = ($urandom_range(0, 9) == 0);
`endif
            @(posedge clk);
            #1;
        end
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
